// File: rtl/uart_rx_fifo.sv
// Byte FIFO downstream of a UART receiver: captures a byte on each busy 1->0 edge, serves it FWFT via valid/ready.
// Optional UART_RX_FIFO_OVERWRITE_EN: when full, a new byte evicts the oldest instead of being dropped.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rd_ready,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(2 ** DEPTH_LOG2);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [2**DEPTH_LOG2];

    logic          push, pop, wr_en, ovf_set;
    logic [PW-1:0] count_w;

    // Pointers carry one extra bit so that full and empty stay distinguishable.
    assign count_w  = wr_ptr_q - rd_ptr_q;
    assign full     = (count_w == DEPTH_CNT);
    assign rd_valid = (count_w != '0);
    assign count    = count_w;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign push = busy_q & ~rx_busy;
    assign pop  = rd_valid & rd_ready;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_d     = rx_busy;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        ovf_set    = 1'b0;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push) begin
            if (!full || pop) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                ovf_set = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
                // Full slot at wr_ptr is the oldest entry; overwrite it and slide the window.
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
            end
        end

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a directed vector table plus hand-written multi-cycle sequences backed by a queue model.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_busy;
    logic [7:0] rx_data;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       overflow_clr;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_busy      (rx_busy),
        .rx_data      (rx_data),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] mq[$];
    logic       m_busy_q;
    logic       m_ovf;

    task automatic check_model(input string tag);
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".valid"}, 32'(rd_valid), 32'(mq.size() > 0));
        check({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) check({tag, ".data"}, 32'(rd_data), 32'(mq[0]));
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_busy = 1'b0; rx_data = 8'h00; rd_ready = 1'b0; overflow_clr = 1'b0;
        @(posedge clk); #1;
        mq.delete(); m_busy_q = 1'b0; m_ovf = 1'b0;
        check_model("reset");
        rst = 1'b0;
    endtask

    // One clock cycle with model update; outputs compared #1 after the edge.
    task automatic cycle(input logic busy, input logic [7:0] data, input logic ready,
                         input logic clr, input string tag);
        logic m_push, m_pop;
        rx_busy = busy; rx_data = data; rd_ready = ready; overflow_clr = clr;
        m_push = m_busy_q && !busy;
        m_pop  = ready && (mq.size() > 0);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(data);
            end else begin
                m_ovf = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
                void'(mq.pop_front());
                mq.push_back(data);
`endif
            end
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (m_push && clr && !(mq.size() == DEPTH && !m_pop)) m_ovf = 1'b0;
        m_busy_q = busy;
        @(posedge clk); #1;
        check_model(tag);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic ready, input logic clr);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, "pb_hi");
        cycle(1'b0, b, ready, clr, "pb_lo");
    endtask

    typedef struct {
        logic       rst;
        logic       busy;
        logic [7:0] data;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [4:0] exp_count;
    } vec_t;

    vec_t vecs[13];

    logic [7:0] last_b;

    initial begin
        // rx_busy held low through reset release, then three bytes and a three-pop drain.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[1]  = '{1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 5'd1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1};
        vecs[6]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hA5, 5'd2};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hA5, 5'd3};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 5'd2};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 5'd1};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};

        rst = 1'b1; rx_busy = 1'b0; rx_data = 8'h00; rd_ready = 1'b0; overflow_clr = 1'b0;
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; rx_busy = vecs[i].busy; rx_data = vecs[i].data; rd_ready = vecs[i].ready;
            @(posedge clk); #1;
            check($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            if (vecs[i].exp_valid) check($sformatf("vec%0d.data", i), 32'(rd_data), 32'(vecs[i].exp_data));
        end

        // 17 pushes with no pops: full after the 16th, overflow after the 17th.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i), 1'b0, 1'b0);
            if (i == 14) check("fill15.full", 32'(full), 32'd0);
            if (i == 15) begin
                check("fill16.full", 32'(full), 32'd1);
                check("fill16.ovf", 32'(overflow), 32'd0);
            end
        end
        check("fill17.ovf", 32'(overflow), 32'd1);
        check("fill17.count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
            check("drain17.data", 32'(rd_data), 32'(i + 1));
`else
            check("drain17.data", 32'(rd_data), 32'(i));
`endif
            cycle(1'b1, 8'h00, 1'b1, 1'b0, "drain17");
        end
        check("drain17.empty", 32'(rd_valid), 32'd0);

        // Full FIFO, push and pop together: count stays 16, no overflow, new byte last.
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i), 1'b0, 1'b0);
        push_byte(8'h77, 1'b1, 1'b0);
        check("pushpop.count", 32'(count), 32'd16);
        check("pushpop.ovf", 32'(overflow), 32'd0);
        check("pushpop.head", 32'(rd_data), 32'h41);

        // Overflow with coincident clear stays set; clear alone then drops it.
        push_byte(8'h99, 1'b0, 1'b0);
        check("ovf.set", 32'(overflow), 32'd1);
        push_byte(8'h9A, 1'b0, 1'b1);
        check("ovf.clr_vs_set", 32'(overflow), 32'd1);
        cycle(1'b1, 8'h00, 1'b0, 1'b1, "ovf_clr");
        check("ovf.clr_alone", 32'(overflow), 32'd0);

        // Drain; 0x77 must be the final byte in the default build.
        last_b = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last_b = rd_data;
            cycle(1'b1, 8'h00, 1'b1, 1'b0, "drain77");
        end
`ifndef UART_RX_FIFO_OVERWRITE_EN
        check("drain77.last", 32'(last_b), 32'h77);
`endif

        // Reset with 5 stored bytes and a busy fall in the reset cycle.
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, "pre_rst");
        check("cnt5", 32'(count), 32'd5);
        rst = 1'b1; rx_busy = 1'b0; rx_data = 8'hEE;
        @(posedge clk); #1;
        check("rst5.count", 32'(count), 32'd0);
        check("rst5.valid", 32'(rd_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("postrst.count", 32'(count), 32'd0);
        mq.delete(); m_busy_q = 1'b0; m_ovf = 1'b0;

        // Interleaved push/pop across several pointer wraps.
        for (int i = 0; i < 80; i++) begin
            cycle(1'(i % 2 == 0), 8'(i * 7 + 3), 1'((i % 4) != 3), 1'b0, "wrap");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
